id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter NB_DATA, 32, datapath width.
REQ-002 SHALL have parameter NB_REG, 5, register-index width.
REQ-003 SHALL have port clock_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port enable_i  input  1  pipeline advance enable (debug step); 0 = hold all state.
REQ-006 SHALL have port flush_i  input  1  kill the instruction currently in ID (taken branch/jump).
REQ-007 SHALL have port id_valid_i  input  1  ID holds a real instruction.
REQ-008 SHALL have ports id_rs_i, id_rt_i, id_rd_i  input  NB_REG  decoded register indices.
REQ-009 SHALL have port id_uses_rt_i  input  1  instruction reads rt as a source.
REQ-010 SHALL have ports id_data_a_i, id_data_b_i, id_imm_i  input  NB_DATA  register-file operands, sign-extended immediate.
REQ-011 SHALL have ports id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i, id_alu_src_i, id_reg_dst_i  input  1  control bits.
REQ-012 SHALL have port id_alu_op_i  input  4  ALU operation code.
REQ-013 SHALL have ex_* outputs, one per id_* input above except id_uses_rt_i, output, same width, registered copy; ex_rs_o/ex_rt_o are the register_a/register_b operands for the forwarding unit.
REQ-014 SHALL have port ex_valid_o  output  1  EX holds a real instruction.
REQ-015 SHALL have port stall_o  output  1  load-use stall request to PC and IF/ID register.
REQ-016 SHALL have port bubble_count_o  output  16  number of bubbles inserted since reset.

Function
REQ-017 SHALL compute stall_o combinationally = enable_i & ~flush_i & id_valid_i & ex_valid_o & ex_mem_read_o & (ex_rt_o != 0) & ((ex_rt_o == id_rs_i) | (id_uses_rt_i & ex_rt_o == id_rt_i)).
REQ-018 SHALL apply, per rising edge, priority: reset > hold (enable_i=0) > flush > stall > load.
REQ-019 Hold SHALL keep every ex_* output, ex_valid_o and bubble_count_o unchanged.
REQ-020 Load SHALL capture every id_* value into its ex_* output and id_valid_i into ex_valid_o, latency exactly one cycle.
REQ-021 Flush or stall SHALL insert a bubble: all ex_* control bits, ex_alu_op_o, indices and data = 0, ex_valid_o = 0.
REQ-022 bubble_count_o SHALL increment by 1 on each bubble inserted by flush or stall, saturating at 0xFFFF (no wrap).
REQ-023 A stall SHALL last exactly one cycle for a given load: after the bubble, ex_valid_o=0 so stall_o deasserts and the held ID instruction loads next edge.
REQ-024 Simultaneous flush_i and load-use condition SHALL produce one bubble, count +1, stall_o=0.
REQ-025 Index 0 in EX SHALL never cause a stall (register $zero).
REQ-026 Outputs SHALL contain no combinational path from id_* data to ex_* outputs.

Reset
REQ-027 While reset_i=0 at an edge, all ex_* outputs, ex_valid_o and bubble_count_o SHALL become 0, regardless of enable_i/flush_i.
REQ-028 stall_o SHALL be 0 in the cycle after reset since ex_valid_o=0.
REQ-029 Reset asserted mid-stall SHALL discard the stall; first post-reset edge with id_valid_i=1 loads normally.

Verification
REQ-030 Load: id_rs=3, id_rt=4, data_a=0x11, imm=0xFFFFFFF0, reg_write=1, valid=1 -> next cycle ex_rs=3, ex_data_a=0x11, ex_imm=0xFFFFFFF0, ex_valid=1.
REQ-031 Load-use: EX holds lw rt=5; ID add rs=5 -> stall_o=1, next edge bubble (ex_valid=0, count=1), following edge add loads, stall_o=0.
REQ-032 rt-only match: EX lw rt=7; ID rt=7, id_uses_rt=0 -> stall_o=0; id_uses_rt=1 -> stall_o=1.
REQ-033 Flush+stall same cycle -> single bubble, count +1, stall_o=0; lw rt=0 with ID rs=0 -> no stall.
REQ-034 enable_i=0 for 3 cycles with changing id_* and flush_i=1 -> all outputs and count unchanged; preset count 0xFFFF + flush -> stays 0xFFFF.
REQ-035 reset_i=0 during stall with count=9 -> all outputs 0, count 0, stall_o=0 next cycle.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble count.
// Ports: clock_i/reset_i (sync, active-low), enable_i hold, flush_i kill,
//   id_* decoded instruction in, ex_* registered copy out, ex_valid_o,
//   stall_o load-use request, bubble_count_o saturating bubble counter.
module id_ex_reg #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               flush_i,
  input  logic               id_valid_i,
  input  logic [NB_REG-1:0]  id_rs_i,
  input  logic [NB_REG-1:0]  id_rt_i,
  input  logic [NB_REG-1:0]  id_rd_i,
  input  logic               id_uses_rt_i,
  input  logic [NB_DATA-1:0] id_data_a_i,
  input  logic [NB_DATA-1:0] id_data_b_i,
  input  logic [NB_DATA-1:0] id_imm_i,
  input  logic               id_reg_write_i,
  input  logic               id_mem_read_i,
  input  logic               id_mem_write_i,
  input  logic               id_mem_to_reg_i,
  input  logic               id_alu_src_i,
  input  logic               id_reg_dst_i,
  input  logic [3:0]         id_alu_op_i,
  output logic [NB_REG-1:0]  ex_rs_o,
  output logic [NB_REG-1:0]  ex_rt_o,
  output logic [NB_REG-1:0]  ex_rd_o,
  output logic [NB_DATA-1:0] ex_data_a_o,
  output logic [NB_DATA-1:0] ex_data_b_o,
  output logic [NB_DATA-1:0] ex_imm_o,
  output logic               ex_reg_write_o,
  output logic               ex_mem_read_o,
  output logic               ex_mem_write_o,
  output logic               ex_mem_to_reg_o,
  output logic               ex_alu_src_o,
  output logic               ex_reg_dst_o,
  output logic [3:0]         ex_alu_op_o,
  output logic               ex_valid_o,
  output logic               stall_o,
  output logic [15:0]        bubble_count_o
);

  logic rs_hit;
  logic rt_hit;
  logic bubble;

  // Register $zero never carries a real dependency.
  assign rs_hit = (ex_rt_o == id_rs_i);
  assign rt_hit = id_uses_rt_i & (ex_rt_o == id_rt_i);

  assign stall_o = enable_i & ~flush_i & id_valid_i
                 & ex_valid_o & ex_mem_read_o
                 & (ex_rt_o != '0)
                 & (rs_hit | rt_hit);

  // A flush already kills the ID instruction, so it absorbs any stall.
  assign bubble = flush_i | stall_o;

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      ex_rs_o         <= '0;
      ex_rt_o         <= '0;
      ex_rd_o         <= '0;
      ex_data_a_o     <= '0;
      ex_data_b_o     <= '0;
      ex_imm_o        <= '0;
      ex_reg_write_o  <= 1'b0;
      ex_mem_read_o   <= 1'b0;
      ex_mem_write_o  <= 1'b0;
      ex_mem_to_reg_o <= 1'b0;
      ex_alu_src_o    <= 1'b0;
      ex_reg_dst_o    <= 1'b0;
      ex_alu_op_o     <= '0;
      ex_valid_o      <= 1'b0;
      bubble_count_o  <= '0;
    end else if (enable_i) begin
      if (bubble) begin
        ex_rs_o         <= '0;
        ex_rt_o         <= '0;
        ex_rd_o         <= '0;
        ex_data_a_o     <= '0;
        ex_data_b_o     <= '0;
        ex_imm_o        <= '0;
        ex_reg_write_o  <= 1'b0;
        ex_mem_read_o   <= 1'b0;
        ex_mem_write_o  <= 1'b0;
        ex_mem_to_reg_o <= 1'b0;
        ex_alu_src_o    <= 1'b0;
        ex_reg_dst_o    <= 1'b0;
        ex_alu_op_o     <= '0;
        ex_valid_o      <= 1'b0;
        if (bubble_count_o != 16'hFFFF)
          bubble_count_o <= bubble_count_o + 16'd1;
      end else begin
        ex_rs_o         <= id_rs_i;
        ex_rt_o         <= id_rt_i;
        ex_rd_o         <= id_rd_i;
        ex_data_a_o     <= id_data_a_i;
        ex_data_b_o     <= id_data_b_i;
        ex_imm_o        <= id_imm_i;
        ex_reg_write_o  <= id_reg_write_i;
        ex_mem_read_o   <= id_mem_read_i;
        ex_mem_write_o  <= id_mem_write_i;
        ex_mem_to_reg_o <= id_mem_to_reg_i;
        ex_alu_src_o    <= id_alu_src_i;
        ex_reg_dst_o    <= id_reg_dst_i;
        ex_alu_op_o     <= id_alu_op_i;
        ex_valid_o      <= id_valid_i;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Table-driven bench for id_ex_reg: load, load-use stall, flush,
// hold, reset priority and bubble counter saturation.
module tb_id_ex_reg;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [5:0]  ctrl;
    logic [3:0]  alu;
  } pipe_t;

  typedef struct {
    logic        rst;
    logic        en;
    logic        fl;
    logic        ut;
    pipe_t       id;
    logic        cs;
    logic        es;
    pipe_t       ex;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i, enable_i, flush_i, id_uses_rt_i;
  pipe_t       id;
  logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
  logic [31:0] ex_data_a_o, ex_data_b_o, ex_imm_o;
  logic        ex_reg_write_o, ex_mem_read_o, ex_mem_write_o;
  logic        ex_mem_to_reg_o, ex_alu_src_o, ex_reg_dst_o;
  logic [3:0]  ex_alu_op_o;
  logic        ex_valid_o, stall_o;
  logic [15:0] bubble_count_o;
  pipe_t       ex;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  id_ex_reg dut (
    .clock_i(clk), .reset_i(reset_i),
    .enable_i(enable_i), .flush_i(flush_i),
    .id_valid_i(id.valid),
    .id_rs_i(id.rs), .id_rt_i(id.rt), .id_rd_i(id.rd),
    .id_uses_rt_i(id_uses_rt_i),
    .id_data_a_i(id.a), .id_data_b_i(id.b),
    .id_imm_i(id.imm),
    .id_reg_write_i(id.ctrl[5]),
    .id_mem_read_i(id.ctrl[4]),
    .id_mem_write_i(id.ctrl[3]),
    .id_mem_to_reg_i(id.ctrl[2]),
    .id_alu_src_i(id.ctrl[1]),
    .id_reg_dst_i(id.ctrl[0]),
    .id_alu_op_i(id.alu),
    .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o),
    .ex_rd_o(ex_rd_o),
    .ex_data_a_o(ex_data_a_o),
    .ex_data_b_o(ex_data_b_o),
    .ex_imm_o(ex_imm_o),
    .ex_reg_write_o(ex_reg_write_o),
    .ex_mem_read_o(ex_mem_read_o),
    .ex_mem_write_o(ex_mem_write_o),
    .ex_mem_to_reg_o(ex_mem_to_reg_o),
    .ex_alu_src_o(ex_alu_src_o),
    .ex_reg_dst_o(ex_reg_dst_o),
    .ex_alu_op_o(ex_alu_op_o),
    .ex_valid_o(ex_valid_o),
    .stall_o(stall_o),
    .bubble_count_o(bubble_count_o)
  );

  assign ex = '{valid: ex_valid_o, rs: ex_rs_o,
                rt: ex_rt_o, rd: ex_rd_o,
                a: ex_data_a_o, b: ex_data_b_o,
                imm: ex_imm_o,
                ctrl: {ex_reg_write_o, ex_mem_read_o,
                       ex_mem_write_o, ex_mem_to_reg_o,
                       ex_alu_src_o, ex_reg_dst_o},
                alu: ex_alu_op_o};

  function automatic pipe_t mk(
    logic v, logic [4:0] rs, logic [4:0] rt,
    logic [4:0] rd, logic [31:0] a, logic [31:0] b,
    logic [31:0] imm, logic [5:0] c, logic [3:0] alu);
    return '{v, rs, rt, rd, a, b, imm, c, alu};
  endfunction

  task automatic add(
    logic rst, logic en, logic fl, logic ut,
    pipe_t i, logic cs, logic es, pipe_t e,
    logic [15:0] cnt);
    vec_t v;
    v = '{rst, en, fl, ut, i, cs, es, e, cnt};
    tbl.push_back(v);
  endtask

  task automatic chk_cnt(string nm, logic [15:0] exp);
    checks++;
    if (bubble_count_o !== exp) begin
      errors++;
      $display("FAIL %s count got %h want %h",
               nm, bubble_count_o, exp);
    end
  endtask

  // ctrl = {reg_write, mem_read, mem_write,
  //         mem_to_reg, alu_src, reg_dst}
  pipe_t Z, ADD1, LW5, ADD5, LW7, RT7, ST7;
  pipe_t LW8, FL8, LW0, R0, JNK;

  initial begin
    Z    = '0;
    ADD1 = mk(1,3,4,2,32'h11,32'h22,
              32'hFFFF_FFF0,6'b100001,4'h2);
    LW5  = mk(1,1,5,0,32'h100,32'h0,
              32'h8,6'b110110,4'h0);
    ADD5 = mk(1,5,6,9,32'h55,32'h66,
              32'h0,6'b100001,4'h2);
    LW7  = mk(1,2,7,0,32'h200,32'h0,
              32'h4,6'b110110,4'h0);
    RT7  = mk(1,1,7,3,32'h1,32'h7,
              32'h7,6'b100010,4'h2);
    ST7  = mk(1,3,7,4,32'h3,32'h77,
              32'h0,6'b100001,4'h3);
    LW8  = mk(1,4,8,0,32'h400,32'h0,
              32'hC,6'b110110,4'h0);
    FL8  = mk(1,8,9,10,32'h8,32'h9,
              32'h0,6'b100001,4'h1);
    LW0  = mk(1,6,0,0,32'h600,32'h0,
              32'h10,6'b110110,4'h0);
    R0   = mk(1,0,0,11,32'hA,32'hB,
              32'h0,6'b100001,4'h4);
    JNK  = mk(1,5,5,5,32'hDEAD,32'hBEEF,
              32'h1234,6'b111111,4'hF);

    // reset wins over hold and flush
    add(0,0,1,1,JNK, 0,0, Z,   0);
    // plain load; latency one cycle
    add(1,1,0,1,ADD1,1,0, ADD1,0);
    add(1,1,0,1,LW5, 1,0, LW5, 0);
    // load-use on rs: one bubble then load
    add(1,1,0,1,ADD5,1,1, Z,   1);
    add(1,1,0,1,ADD5,1,0, ADD5,1);
    // rt match only matters when rt is read
    add(1,1,0,1,LW7, 1,0, LW7, 1);
    add(1,1,0,0,RT7, 1,0, RT7, 1);
    add(1,1,0,1,LW7, 1,0, LW7, 1);
    add(1,1,0,1,ST7, 1,1, Z,   2);
    add(1,1,0,1,ST7, 1,0, ST7, 2);
    // flush with hazard: single bubble, no stall
    add(1,1,0,1,LW8, 1,0, LW8, 2);
    add(1,1,1,1,FL8, 1,0, Z,   3);
    // load to $zero never stalls
    add(1,1,0,1,LW0, 1,0, LW0, 3);
    add(1,1,0,1,R0,  1,0, R0,  3);
    // hold beats flush, inputs moving
    add(1,0,1,1,JNK, 1,0, R0,  3);
    add(1,0,1,1,LW5, 1,0, R0,  3);
    add(1,0,1,0,ADD1,1,0, R0,  3);
    // flushes up to count 9
    for (int k = 4; k <= 9; k++)
      add(1,1,1,1,JNK,1,0, Z, 16'(k));
    // reset during a pending stall
    add(1,1,0,1,LW5, 1,0, LW5, 9);
    add(0,1,0,1,ADD5,1,1, Z,   0);
    add(1,1,0,1,ADD5,1,0, ADD5,0);

    reset_i = 1'b0; enable_i = 1'b0;
    flush_i = 1'b0; id_uses_rt_i = 1'b0; id = '0;

    foreach (tbl[i]) begin
      @(negedge clk);
      reset_i      = tbl[i].rst;
      enable_i     = tbl[i].en;
      flush_i      = tbl[i].fl;
      id_uses_rt_i = tbl[i].ut;
      id           = tbl[i].id;
      #1;
      if (tbl[i].cs) begin
        checks++;
        if (stall_o !== tbl[i].es) begin
          errors++;
          $display("FAIL row%0d stall got %b want %b",
                   i, stall_o, tbl[i].es);
        end
      end
      @(posedge clk); #1;
      checks++;
      if (ex !== tbl[i].ex) begin
        errors++;
        $display("FAIL row%0d ex got %h want %h",
                 i, ex, tbl[i].ex);
      end
      chk_cnt($sformatf("row%0d", i), tbl[i].cnt);
    end

    // stall_o low right after a reset
    @(negedge clk);
    reset_i = 1'b0; id = ADD5; id_uses_rt_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL post_rst stall got %b want 0",
               stall_o);
    end

    // saturation: 65534 flushes, then two more
    @(negedge clk);
    enable_i = 1'b1; flush_i = 1'b1; id = JNK;
    repeat (65534) @(posedge clk);
    #1 chk_cnt("sat_fffe", 16'hFFFE);
    @(posedge clk); #1 chk_cnt("sat_ffff", 16'hFFFF);
    @(posedge clk); #1 chk_cnt("sat_hold", 16'hFFFF);
    @(negedge clk); enable_i = 1'b0;
    @(posedge clk); #1 chk_cnt("sat_en0", 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
